// File: rtl/gpu_op_arbiter.sv
// gpu_op_arbiter
// Round-robin arbiter sharing the single GPU op port between NUM_REQ
// producers. A producer keeps the grant for a whole burst, which ends with
// its req_last flag, so its ops reach the GPU as one contiguous sequence.
// The output op is registered.
//
// Optional feature: define GPU_OP_ARBITER_TIMEOUT_EN to build an idle-grant
// watchdog. The watchdog releases an owner that stops presenting ops for
// TIMEOUT enabled cycles.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ce                    clock enable; low freezes all state and handshakes
//   req_op/valid/last     per-requester op, valid and end-of-burst flag
//   req_ready             per-requester accept (combinational)
//   grant                 one-hot current owner, registered (0 when idle)
//   op, op_valid          registered op to the GPU
//   op_ready              GPU accept

package gpu_op_arbiter_pkg;
    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] w;
        logic [11:0] h;
        logic [11:0] color;
    } gpu_op_t;
endpackage

// Per-requester handshake qualification.
module gpu_op_arbiter_lane (
    input  logic ce,
    input  logic owner,
    input  logic out_free,
    input  logic valid,
    output logic ready,
    output logic accept
);
    assign ready  = ce && owner && out_free;
    assign accept = valid && ready;
endmodule

module gpu_op_arbiter
    import gpu_op_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  gpu_op_t [NUM_REQ-1:0] req_op,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output gpu_op_t              op,
    output logic                 op_valid,
    input  logic                 op_ready
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {ARBITRATE, GRANTED} state_t;

    state_t              state;
    // Index of the current (or most recent) owner; the search starts after it.
    logic [IW-1:0]       last_grant;
    logic [IW-1:0]       winner;
    logic [IW-1:0]       cand;
    logic [NUM_REQ-1:0]  winner_oh;
    logic [NUM_REQ-1:0]  lane_accept;
    logic                out_free;
    logic                accept;

    // The output register can take a new op if empty or draining this cycle.
    assign out_free = !op_valid || op_ready;

    // grant is all-zero outside GRANTED, so it alone gates req_ready.
    gpu_op_arbiter_lane u_lane [NUM_REQ-1:0] (
        .ce       (ce),
        .owner    (grant),
        .out_free (out_free),
        .valid    (req_valid),
        .ready    (req_ready),
        .accept   (lane_accept)
    );

    assign accept = |lane_accept;

    // Round-robin search. Walk offsets from farthest to nearest so the
    // nearest valid requester after last_grant is the final (winning) write.
    always_comb begin
        int c;
        winner = last_grant;
        cand   = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = int'(last_grant) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = IW'(c);
            if (req_valid[cand]) winner = cand;
        end
    end

    always_comb begin
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
    end

`ifdef GPU_OP_ARBITER_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT) + 1 > 11) ? $clog2(TIMEOUT) + 1 : 11;
    logic [WDW-1:0] wd_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARBITRATE;
            grant      <= '0;
            op         <= '0;
            op_valid   <= 1'b0;
            last_grant <= IW'(NUM_REQ - 1);
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else if (ce) begin
            // Drain; a same-edge accept below overrides this.
            if (op_valid && op_ready) op_valid <= 1'b0;

            case (state)
                ARBITRATE: begin
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    if (|req_valid) begin
                        grant      <= winner_oh;
                        last_grant <= winner;
                        state      <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (accept) begin
                        op       <= req_op[last_grant];
                        op_valid <= 1'b1;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                        if (req_last[last_grant]) begin
                            grant <= '0;
                            state <= ARBITRATE;
                        end
                    end
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
                    // Owner gone quiet: release it. last_grant keeps the
                    // timed-out requester so the others are searched first.
                    else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                        grant  <= '0;
                        state  <= ARBITRATE;
                        wd_cnt <= '0;
                    end else if (!req_valid[last_grant]) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ARBITRATE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_op_arbiter.sv
module tb_gpu_op_arbiter;
    import gpu_op_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ce = 1'b0;
    logic            op_ready = 1'b0;
    gpu_op_t [N-1:0] req_op;
    logic [N-1:0]    req_valid, req_last, req_ready, grant;
    gpu_op_t         op;
    logic            op_valid;

    int vectors = 0;
    int errors  = 0;
    bit started = 1'b0;

    gpu_op_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req_op(req_op), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .op(op), .op_valid(op_valid), .op_ready(op_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // owner = index of the granted requester, -1 when idle.
    int      m_owner = -1;
    int      m_last  = N - 1;
    int      m_cnt   = 0;
    logic    m_vld   = 1'b0;
    gpu_op_t m_op    = '0;

    always @(posedge clk or posedge rst) begin
        bit acc;
        int c;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_cnt = 0; m_vld = 1'b0; m_op = '0;
        end else if (ce) begin
            acc = (m_owner >= 0) && (!m_vld || op_ready) && req_valid[m_owner];
            if (acc) begin
                m_op  = req_op[m_owner];
                m_vld = 1'b1;
            end else if (m_vld && op_ready) begin
                m_vld = 1'b0;
            end
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (m_owner < 0 && req_valid[c]) begin
                        m_owner = c;
                        m_last  = c;
                    end
                end
            end else if (acc) begin
                m_cnt = 0;
                if (req_last[m_owner]) m_owner = -1;
            end
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
            else if (m_cnt == TMO - 1) begin
                m_owner = -1;
                m_cnt   = 0;
            end else if (!req_valid[m_owner]) begin
                m_cnt++;
            end
`endif
        end
    end

    // Compare every cycle, mid-way between active edges.
    always @(negedge clk) begin
        logic [N-1:0] eg, er;
        if (started) begin
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            er = '0;
            for (int i = 0; i < N; i++)
                er[i] = ce && (m_owner == i) && (!m_vld || op_ready);
            chk("grant", grant, eg);
            chk("op_valid", op_valid, m_vld);
            if (m_vld) chk("op", op, m_op);
            chk("req_ready", req_ready, er);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic gpu_op_t mk(input int x);
        mk       = '0;
        mk.x     = x[11:0];
        mk.color = 12'habc;
    endfunction

    logic [N-1:0] rr_exp [7];
    logic [N-1:0] acc;
    int           cnt [N];
    logic [63:0]  rnd;

    initial begin
        rr_exp[0] = 3'b010; rr_exp[1] = 3'b010; rr_exp[2] = 3'b000;
        rr_exp[3] = 3'b001; rr_exp[4] = 3'b001; rr_exp[5] = 3'b000;
        rr_exp[6] = 3'b010;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        ce = 1'b1; op_ready = 1'b1;
        req_valid = '0; req_last = '0; req_op = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        started = 1'b1;
        chk("rst_grant", grant, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op", op, 0);

        // Single 4-op burst from requester 0.
        req_valid = 3'b001; req_op[0] = mk(0);
        tick();
        chk("t1_arb_grant", grant, 3'b001);
        chk("t1_arb_vld", op_valid, 0);
        for (int x = 0; x < 4; x++) begin
            req_op[0] = mk(x); req_last[0] = (x == 3);
            tick();
            chk("t1_op_x", op.x, x);
            chk("t1_vld", op_valid, 1);
            chk("t1_grant", grant, (x == 3) ? 3'b000 : 3'b001);
        end
        req_valid = '0; req_last = '0;
        tick();
        chk("t1_drain", op_valid, 0);

        // Two requesters with 2-op bursts: alternation with a 1-cycle gap.
        req_valid = 3'b011;
        for (int e = 0; e < 7; e++) begin
            for (int i = 0; i < N; i++) begin
                req_last[i] = cnt[i][0];
                req_op[i]   = mk(100 + 10 * i + cnt[i]);
            end
            #1;
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
            chk("rr_grant", grant, rr_exp[e]);
        end
        req_valid = 3'b010; req_last = 3'b010;
        tick();
        chk("rr_end", grant, 0);
        req_valid = '0; req_last = '0;
        tick();

        // Clock enable low mid-burst (requester 2 wins after 1).
        req_valid = 3'b100; req_op[2] = mk(7);
        tick();
        chk("ce_arb", grant, 3'b100);
        tick();
        req_op[2] = mk(8);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ce_rdy", req_ready, 0);
            tick();
            chk("ce_grant", grant, 3'b100);
            chk("ce_op", op, mk(7));
            chk("ce_vld", op_valid, 1);
        end
        ce = 1'b1; req_last[2] = 1'b1;
        tick();
        chk("ce_resume_op", op, mk(8));
        chk("ce_resume_grant", grant, 0);
        req_valid = '0; req_last = '0;
        tick();

        // Wrap to requester 0, then async reset mid-burst.
        req_valid = 3'b011; req_op[0] = mk(20); req_op[1] = mk(21);
        tick();
        chk("wrap_grant", grant, 3'b001);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", op_valid, 0);
        chk("arst_grant", grant, 0);
        rst = 1'b0;
        tick();
        chk("arst_first", grant, 3'b001);
        req_last = 3'b011;
        tick();
        req_valid = '0; req_last = '0;
        tick();

        // Owner goes quiet mid-burst while requester 1 waits.
        req_valid = 3'b001; req_op[0] = mk(30);
        tick();
        tick();
        req_valid = 3'b010; req_op[1] = mk(31);
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
        repeat (4) tick();
        chk("wd_release", grant, 0);
        tick();
        chk("wd_regrant", grant, 3'b010);
        req_last = 3'b010;
        tick();
`else
        repeat (100) tick();
        chk("no_wd_blocked", grant, 3'b001);
        req_valid = 3'b001; req_last = 3'b001;
        tick();
`endif
        req_valid = '0; req_last = '0;
        tick();

        // Randomized traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_last[i]  = ($urandom_range(0, 3) == 0);
                rnd          = {$urandom, $urandom};
                req_op[i]    = rnd[59:0];
            end
            op_ready = ($urandom_range(0, 3) != 0);
            ce       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/gpu_op_arbiter.md
# gpu_op_arbiter

Round-robin arbiter that shares the single GPU operation port (`gpu_op_t op` / `op_valid` / `op_ready`) between several op producers, e.g. the game-logic CPU and a HUD/score overlay engine. A requester holds the grant for a burst of ops, terminated by its `req_last` flag, so a producer's rectangles reach the GPU as one contiguous sequence. The block sits between the producers and the GPU op input and registers the output op.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 256: idle-grant watchdog limit in enabled cycles; used only with `GPU_OP_ARBITER_TIMEOUT_EN`.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ce` in 1: clock enable; when low, all state holds and no handshake completes.
- `req_op` in `gpu_op_t [NUM_REQ-1:0]`: per-requester op (60-bit packed struct).
- `req_valid` in NUM_REQ: per-requester op valid.
- `req_last` in NUM_REQ: qualifies `req_op`; marks the final op of a burst.
- `req_ready` out NUM_REQ: per-requester accept, combinational.
- `grant` out NUM_REQ: one-hot current owner, registered; all-zero when idle.
- `op` out `gpu_op_t`: registered op to the GPU.
- `op_valid` out 1: registered.
- `op_ready` in 1: GPU accept.

## Operation
- States: `ARBITRATE`, `GRANTED`.
- `ARBITRATE`:
  - If any `req_valid` is set, pick the first set bit searching upward from `last_grant+1` with wrap-around.
  - Set `grant` to the one-hot of the winner, store `last_grant`, then move to `GRANTED`.
  - No op is accepted in this state.
- `GRANTED`:
  - `req_ready[i] = ce && grant[i] && (!op_valid || op_ready)`; all other bits are 0.
  - Accept (`req_valid[g] && req_ready[g]`): `op <= req_op[g]`, `op_valid <= 1`.
  - Accept with `req_last[g]=1`: `grant <= 0` and go to `ARBITRATE` on the same edge.
- Output: `op_valid && op_ready && ce` with no simultaneous accept gives `op_valid <= 0`. With a simultaneous accept, `op` is replaced and `op_valid` stays 1.
- The owner deasserting `req_valid` mid-burst does not release the grant; the arbiter waits indefinitely unless the watchdog is compiled in.
- `op` holds its value while `op_valid=1 && !op_ready`. It is not required to be stable when `op_valid=0`.

## Timing
- Reset values:
  - State `ARBITRATE`, `grant=0`, `op=0`, `op_valid=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
  - Watchdog counter 0.
- Reset mid-burst clears `op_valid` immediately (asynchronously). The in-flight op is discarded and the owner must resend its burst.
- Arbitration costs 1 enabled cycle. Request seen at edge N gives `grant` at edge N+1, and the first accept can occur in the cycle after edge N+1.
- Op latency: accepted at edge N, `op_valid` is high after edge N, i.e. in the next cycle.
- Throughput: 1 op per enabled cycle while `op_ready=1`.
- Gap after `req_last`: 1 cycle with no accept (arbitration), even if the same requester re-requests.
- Fairness: after requester i finishes a burst, every other valid requester is granted before i again.

## Configuration
- `GPU_OP_ARBITER_TIMEOUT_EN` defined:
  - In `GRANTED`, an 11-bit-or-wider counter increments on each enabled cycle with `req_valid[g]=0`, and clears on any accept.
  - When it reaches `TIMEOUT-1`, the next enabled edge sets `grant <= 0` and goes to `ARBITRATE`; `last_grant` stays as the timed-out requester.
  - An op already in the output register is still delivered.
- Not defined: no counter is built, and the grant is released only by `req_last`.

## Test plan
- Reset, then requester 0 sends ops x=0..3 with last on x=3 and `op_ready=1`: `grant=01` one cycle after request, four consecutive ops on `op`, `grant=00` after the 4th accept.
- Both requesters valid continuously with 2-op bursts: grants alternate 01,10,01,10, with exactly 1 idle cycle between bursts.
- `op_ready` held low for 5 cycles with `op_valid=1`: `op` stable, `req_ready=0`; on release, 1 op per cycle resumes with no loss or duplication.
- `ce` low for 3 cycles mid-burst: `grant`, `op`, `op_valid` unchanged, `req_ready=0`.
- Async `rst` pulse between clock edges mid-burst: `op_valid=0` and `grant=0` immediately; after release, requester 0 wins first.
- With `GPU_OP_ARBITER_TIMEOUT_EN` and `TIMEOUT=4`: owner drops valid mid-burst while requester 1 waits; grant moves to 10 after 4 idle cycles plus 1 arbitration cycle. Without the macro, requester 1 stays blocked for 100 cycles.
